// File: rtl/ask_demodulator.sv
// ASK receiver: per-frame PWM duty deviation, windowed peak, hysteresis + debounce.
// Define ASK_DEMOD_PEAK_OUT_EN to add the o_peak window-peak output.
module ask_demodulator #(
  parameter int PWM_LOG2      = 6,
  parameter int WINDOW_FRAMES = 16,
  parameter int ON_THRESH     = 8,
  parameter int OFF_THRESH    = 4,
  parameter int DEBOUNCE      = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ask_in,
  output logic o_data,
  output logic o_data_valid,
  output logic o_clk_en
`ifdef ASK_DEMOD_PEAK_OUT_EN
  ,
  output logic [PWM_LOG2-1:0] o_peak
`endif
);

  localparam int FW  = PWM_LOG2;
  localparam int MID = 1 << (PWM_LOG2 - 1);
  localparam int IW  = (WINDOW_FRAMES > 1) ? $clog2(WINDOW_FRAMES) : 1;
  localparam int DW  = $clog2(DEBOUNCE + 1);

  localparam logic [FW:0]   MID_H    = (FW+1)'(MID);
  localparam logic [IW-1:0] LAST_IDX = IW'(WINDOW_FRAMES - 1);
  localparam logic [FW-1:0] ON_T     = FW'(ON_THRESH);
  localparam logic [FW-1:0] OFF_T    = FW'(OFF_THRESH);
  localparam logic [DW-1:0] DB_T     = DW'(DEBOUNCE);

  localparam logic [0:0] S_OFF = 1'b0;
  localparam logic [0:0] S_ON  = 1'b1;

  logic          sync1;
  logic          s;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] hi_cnt;
  logic [IW-1:0] frame_idx;
  logic [FW-1:0] peak;
  logic [DW-1:0] db_cnt;
  logic [0:0]    state;

  logic          frame_end;
  logic          window_end;
  logic [FW:0]   h;
  logic [FW-1:0] dev;
  logic [FW-1:0] pk;
  logic          raw_diff;
  logic [DW-1:0] db_inc;
  logic          flip;

  always_comb begin
    frame_end  = &frame_cnt;
    window_end = frame_end && (frame_idx == LAST_IDX);
    h = {1'b0, hi_cnt} + {{FW{1'b0}}, s};
    if (h >= MID_H) begin
      dev = FW'(h - MID_H);
    end else begin
      dev = FW'(MID_H - h);
    end
    pk = (dev > peak) ? dev : peak;
    raw_diff = 1'b0;
    unique case (1'b1)
      (state == S_ON):  raw_diff = (pk <= OFF_T);
      (state == S_OFF): raw_diff = (pk >= ON_T);
    endcase
    db_inc = db_cnt + DW'(1);
    flip   = raw_diff && (db_inc == DB_T);
  end

  // A frame is any 2^PWM_LOG2-cycle span; no alignment to the carrier needed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1        <= 1'b0;
      s            <= 1'b0;
      frame_cnt    <= '0;
      hi_cnt       <= '0;
      frame_idx    <= '0;
      peak         <= '0;
      db_cnt       <= '0;
      state        <= S_OFF;
      o_data_valid <= 1'b0;
    end else begin
      sync1        <= i_ask_in;
      s            <= sync1;
      frame_cnt    <= frame_cnt + FW'(1);
      o_data_valid <= window_end;
      if (frame_end) begin
        hi_cnt <= '0;
      end else begin
        hi_cnt <= hi_cnt + {{(FW-1){1'b0}}, s};
      end
      if (window_end) begin
        frame_idx <= '0;
        peak      <= '0;
        if (flip || !raw_diff) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_inc;
        end
        if (flip) begin
          state <= ~state;
        end
      end else if (frame_end) begin
        frame_idx <= frame_idx + IW'(1);
        peak      <= pk;
      end
    end
  end

`ifdef ASK_DEMOD_PEAK_OUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_peak <= '0;
    end else if (window_end) begin
      o_peak <= pk;
    end
  end
`endif

  assign o_data   = state[0];
  assign o_clk_en = 1'b1;

endmodule

// File: tb/tb_ask_demodulator.sv
// Randomized scoreboard bench for ask_demodulator against a
// window-level reference model of the demodulation rules.
module tb_ask_demodulator;

  localparam int PWM_LOG2 = 6;
  localparam int FRAME    = 1 << PWM_LOG2;
  localparam int MID      = FRAME / 2;
  localparam int WF       = 16;
  localparam int WIN      = WF * FRAME;
  localparam int ON_T     = 8;
  localparam int OFF_T    = 4;
  localparam int DEB      = 2;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_ask_in = 1'b0;
  logic o_data;
  logic o_data_valid;
  logic o_clk_en;
`ifdef ASK_DEMOD_PEAK_OUT_EN
  logic [PWM_LOG2-1:0] o_peak;
`endif

  ask_demodulator #(
    .PWM_LOG2(PWM_LOG2),
    .WINDOW_FRAMES(WF),
    .ON_THRESH(ON_T),
    .OFF_THRESH(OFF_T),
    .DEBOUNCE(DEB)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_ask_in(i_ask_in),
    .o_data(o_data),
    .o_data_valid(o_data_valid),
    .o_clk_en(o_clk_en)
`ifdef ASK_DEMOD_PEAK_OUT_EN
    ,
    .o_peak(o_peak)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit data;
    int pk;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  bit hist[$];
  int cyc, fsum, fpeak, nframe, m_run;
  bit m_data;

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    cyc = 0; fsum = 0; fpeak = 0;
    nframe = 0; m_run = 0; m_data = 1'b0;
  endtask

  task automatic decide(input int pk);
    exp_t e;
    bit disagree;
    disagree = m_data ? (pk <= OFF_T) : (pk >= ON_T);
    m_run = disagree ? m_run + 1 : 0;
    if (m_run >= DEB) begin
      m_data = !m_data;
      m_run = 0;
    end
    e.data = m_data;
    e.pk = pk;
    exp_q.push_back(e);
  endtask

  // Model sees each driven bit two cycles late (input synchronizer).
  task automatic step(input bit v);
    int sv, dev;
    i_ask_in = v;
    hist.push_back(v);
    sv = (cyc >= 2) ? int'(hist[cyc-2]) : 0;
    fsum += sv;
    if (cyc % FRAME == FRAME - 1) begin
      dev = (fsum > MID) ? fsum - MID : MID - fsum;
      if (dev > fpeak) fpeak = dev;
      fsum = 0;
      nframe++;
      if (nframe % WF == 0) begin
        decide(fpeak);
        fpeak = 0;
      end
    end
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic frame(input int h, input int ph);
    for (int i = 0; i < FRAME; i++) step(((i + ph) % FRAME) < h);
  endtask

  task automatic window(input int h, input int ph);
    for (int f = 0; f < WF; f++) frame(h, ph);
  endtask

  task automatic frames(input int n, input int h);
    for (int f = 0; f < n; f++) frame(h, 0);
  endtask

  task automatic noise_window();
    for (int i = 0; i < WIN; i++) step(1'($urandom));
  endtask

  task automatic rand_window();
    int lvl;
    lvl = $urandom_range(0, 5);
    for (int f = 0; f < WF; f++) begin
      case (lvl)
        0: frame(32, $urandom_range(0, 63));
        1: frame(36, 0);
        2: frame(38, 0);
        3: frame(64, 0);
        4: frame(0, 0);
        default: frame($urandom_range(20, 44), $urandom_range(0, 63));
      endcase
    end
  endtask

  task automatic do_reset(input int n);
    i_rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_ask_in = 1'($urandom);
      @(posedge i_clk);
      #1;
    end
    i_rst_n = 1'b1;
    model_reset();
  endtask

  logic rst_edge = 1'b1;
  always @(posedge i_clk) rst_edge <= !i_rst_n;

  int since = 0;
  bit cur = 1'b0;
  always @(negedge i_clk) begin
    exp_t e;
    if (rst_edge) begin
      checks += 2;
      if (o_data !== 1'b0) begin
        errors++;
        $display("FAIL reset_data: got %b want 0", o_data);
      end
      if (o_data_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid: got %b want 0", o_data_valid);
      end
      since = 0;
      cur = 1'b0;
    end else begin
      since++;
      if (o_data_valid === 1'b1) begin
        checks += 2;
        if (since != WIN) begin
          errors++;
          $display("FAIL period: got %0d want %0d", since, WIN);
        end
        if (o_clk_en !== 1'b1) begin
          errors++;
          $display("FAIL clk_en: got %b want 1", o_clk_en);
        end
        since = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got pulse want none");
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e.data) begin
            errors++;
            $display("FAIL window_data: got %b want %b", o_data, e.data);
          end
          cur = e.data;
`ifdef ASK_DEMOD_PEAK_OUT_EN
          checks++;
          if (int'(o_peak) != e.pk) begin
            errors++;
            $display("FAIL peak: got %0d want %0d", o_peak, e.pk);
          end
`endif
        end
      end else begin
        checks++;
        if (o_data !== cur) begin
          errors++;
          $display("FAIL hold_data: got %b want %b", o_data, cur);
        end
        if (since == WIN + 16) begin
          checks++;
          errors++;
          $display("FAIL timeout: got no valid in %0d cycles want %0d", since, WIN);
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset(10);
    for (int w = 0; w < 5; w++) window(32, 17);
    for (int w = 0; w < 3; w++) window(64, 0);
    for (int w = 0; w < 3; w++) window(32, $urandom_range(0, 63));
    for (int w = 0; w < 3; w++) window(38, 0);
    for (int w = 0; w < 2; w++) window(64, 0);
    for (int w = 0; w < 3; w++) window(38, 0);
    for (int w = 0; w < 2; w++) window(36, 0);
    window(32, 5);
    window(64, 0);
    window(32, 9);
    window(32, 40);
    for (int w = 0; w < 6; w++) rand_window();
    noise_window();
    noise_window();
    for (int w = 0; w < 2; w++) window(64, 0);
    frames(WF / 2, 64);
    do_reset(1);
    window(64, 0);
    window(32, 3);
    window(32, 3);
    repeat (2) @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d unchecked windows want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
